// File: rtl/fp_flag_pkg.sv
// Shared definitions for the FP exception-flag collector: flag bit positions,
// host register addresses and the RUN/TRAP state type.
package fp_flag_pkg;

  localparam int FLAG_W = 5;

  localparam int FLG_OF = 4;
  localparam int FLG_UF = 3;
  localparam int FLG_DZ = 2;
  localparam int FLG_NV = 1;
  localparam int FLG_NX = 0;

  localparam logic [3:0] ADDR_STATUS      = 4'd0;
  localparam logic [3:0] ADDR_ENABLE      = 4'd1;
  localparam logic [3:0] ADDR_LAST_RESULT = 4'd2;
  localparam logic [3:0] ADDR_CNT         = 4'd3;
  localparam logic [3:0] ADDR_FCNT0       = 4'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

endpackage

// File: rtl/fp_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module fp_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fp_flag_collector.sv
// Sink of the FP exception-flag stream: sticky status, last result, trap/stall
// and a host register port. Define FP_FLAG_COUNTERS_EN to add per-flag counters.
module fp_flag_collector
  import fp_flag_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic [31:0]       in_result,
  input  logic              csr_wr,
  input  logic              csr_rd,
  input  logic [3:0]        csr_addr,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata,
  output logic              csr_rvalid,
  output logic              irq
);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              irq_q, irq_d;
  logic [FLAG_W-1:0] status_q, status_d;
  logic [FLAG_W-1:0] enable_q, enable_d;
  logic [FLAG_W-1:0] last_flags_q, last_flags_d;
  logic [31:0]       last_result_q, last_result_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rd_word;
  logic [CNT_W-1:0]  cnt;
  logic              xfer;
  logic              unused_wdata;

  assign xfer         = in_valid & in_ready_q;
  assign unused_wdata = ^csr_wdata[31:FLAG_W];

  fp_sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (xfer & (|in_flags)),
    .clr   (csr_wr && (csr_addr == ADDR_CNT)),
    .count (cnt)
  );

`ifdef FP_FLAG_COUNTERS_EN
  logic [CNT_W-1:0] fcnt [FLAG_W];

  for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_fcnt
    fp_sat_counter #(.W(CNT_W)) u_fcnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (xfer & in_flags[gi]),
      .clr   (csr_wr && (csr_addr == (ADDR_FCNT0 + 4'(gi)))),
      .count (fcnt[gi])
    );
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (xfer && (|(in_flags & enable_q))) state_d = ST_TRAP;
      ST_TRAP: if (!(|(status_q & enable_q)))        state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    in_ready_d = (state_d == ST_RUN);
    irq_d      = (state_d == ST_TRAP);
  end

  // Clear-then-set ordering makes a concurrent flag set win over write-1-clear.
  always_comb begin
    status_d      = status_q;
    enable_d      = enable_q;
    last_flags_d  = last_flags_q;
    last_result_d = last_result_q;
    if (csr_wr && (csr_addr == ADDR_STATUS)) status_d = status_q & ~csr_wdata[FLAG_W-1:0];
    if (csr_wr && (csr_addr == ADDR_ENABLE)) enable_d = csr_wdata[FLAG_W-1:0];
    if (xfer) begin
      status_d      = status_d | in_flags;
      last_flags_d  = in_flags;
      last_result_d = in_result;
    end
  end

  always_comb begin
    rd_word = '0;
    case (csr_addr)
      ADDR_STATUS:      rd_word[FLAG_W-1:0] = status_q;
      ADDR_ENABLE:      rd_word[FLAG_W-1:0] = enable_q;
      ADDR_LAST_RESULT: rd_word = last_result_q;
      ADDR_CNT: begin
        rd_word[CNT_W-1:0] = cnt;
        rd_word[20:16]     = last_flags_q;
      end
      default: begin
`ifdef FP_FLAG_COUNTERS_EN
        for (int i = 0; i < FLAG_W; i++) begin
          if (csr_addr == (ADDR_FCNT0 + 4'(i))) rd_word[CNT_W-1:0] = fcnt[i];
        end
`endif
      end
    endcase
    rdata_d  = csr_rd ? rd_word : rdata_q;
    rvalid_d = csr_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      in_ready_q    <= 1'b0;
      irq_q         <= 1'b0;
      status_q      <= '0;
      enable_q      <= '0;
      last_flags_q  <= '0;
      last_result_q <= '0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      irq_q         <= irq_d;
      status_q      <= status_d;
      enable_q      <= enable_d;
      last_flags_q  <= last_flags_d;
      last_result_q <= last_result_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign irq        = irq_q;
  assign csr_rdata  = rdata_q;
  assign csr_rvalid = rvalid_q;

endmodule

// File: tb/tb_fp_flag_collector.sv
// Self-checking bench for fp_flag_collector: directed scenarios plus random
// traffic, checked against a behavioural register/trap model.
module tb_fp_flag_collector;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_flags;
  logic [31:0] in_result;
  logic        csr_wr;
  logic        csr_rd;
  logic [3:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic        in_ready;
  logic        irq;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_trap;
  bit          m_ready;
  logic [4:0]  m_status;
  logic [4:0]  m_enable;
  logic [4:0]  m_lflags;
  logic [31:0] m_lres;
  int          m_cnt;
  int          m_fcnt [5];

  fp_flag_collector #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flags   (in_flags),
    .in_result  (in_result),
    .csr_wr     (csr_wr),
    .csr_rd     (csr_rd),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_rvalid (csr_rvalid),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(logic [3:0] a);
    logic [31:0] v;
    v = '0;
    if (a == 4'd0)      v = 32'(m_status);
    else if (a == 4'd1) v = 32'(m_enable);
    else if (a == 4'd2) v = m_lres;
    else if (a == 4'd3) v = (32'(m_lflags) << 16) + 32'(m_cnt);
`ifdef FP_FLAG_COUNTERS_EN
    else if (a >= 4'd4 && a <= 4'd8) v = 32'(m_fcnt[int'(a) - 4]);
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_trap = 0; m_ready = 0;
    m_status = '0; m_enable = '0; m_lflags = '0; m_lres = '0; m_cnt = 0;
    for (int i = 0; i < 5; i++) m_fcnt[i] = 0;
  endtask

  // One clock: update the model from the driven inputs, then check outputs.
  task automatic step();
    bit acc, rd, nt;
    logic [31:0] rexp;
    logic [3:0] a;
    acc  = in_valid && m_ready && !rst;
    rd   = csr_rd && !rst;
    a    = csr_addr;
    rexp = model_read(csr_addr);
    if (rst) begin
      model_reset();
    end else begin
      nt = m_trap ? ((m_status & m_enable) != 0) : (acc && ((in_flags & m_enable) != 0));
      if (csr_wr && csr_addr == 4'd0) m_status = m_status & ~csr_wdata[4:0];
      if (csr_wr && csr_addr == 4'd1) m_enable = csr_wdata[4:0];
      if (acc) begin
        m_status = m_status | in_flags;
        m_lflags = in_flags;
        m_lres   = in_result;
        if (in_flags != 0 && m_cnt < CNT_MAX) m_cnt++;
        for (int i = 0; i < 5; i++) if (in_flags[i] && m_fcnt[i] < CNT_MAX) m_fcnt[i]++;
      end
      if (csr_wr && csr_addr == 4'd3) m_cnt = 0;
      for (int i = 0; i < 5; i++) if (csr_wr && int'(csr_addr) == 4 + i) m_fcnt[i] = 0;
      m_trap  = nt;
      m_ready = !nt;
    end
    @(posedge clk); #1;
    check("in_ready", 32'(in_ready), 32'(m_ready));
    check("irq", 32'(irq), 32'(m_trap));
    check("rvalid", 32'(csr_rvalid), 32'(rd));
    if (rd) check($sformatf("rdata_a%0d", a), csr_rdata, rexp);
  endtask

  task automatic xfer(logic [4:0] f, logic [31:0] r);
    in_valid = 1; in_flags = f; in_result = r;
    $display("xfer flags=%b result=%h ready=%0b", f, r, in_ready);
    step();
    in_valid = 0;
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    csr_wr = 1; csr_addr = a; csr_wdata = d;
    $display("write addr=%0d data=%h", a, d);
    step();
    csr_wr = 0;
  endtask

  task automatic rd_chk(logic [3:0] a, logic [31:0] exp);
    csr_rd = 1; csr_addr = a;
    step();
    csr_rd = 0;
    $display("read addr=%0d data=%h", a, csr_rdata);
    check($sformatf("const_a%0d", a), csr_rdata, exp);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_flags = '0; in_result = '0;
    csr_wr = 0; csr_rd = 0; csr_addr = '0; csr_wdata = '0;
    model_reset();
    #1;
    step(); step();
    rst = 0;
    step();
    check("ready_after_reset", 32'(in_ready), 32'd1);
    check("irq_after_reset", 32'(irq), 32'd0);
    for (int a = 0; a < 4; a++) rd_chk(4'(a), 32'h0);

    // Sticky accumulation with no enables
    xfer(5'b00001, 32'h3F800000);
    xfer(5'b10000, 32'h7F800000);
    xfer(5'b00000, 32'h40490FDB);
    rd_chk(4'd0, 32'h0000_0011);
    rd_chk(4'd3, 32'h0000_0002);
    rd_chk(4'd2, 32'h40490FDB);

    // Trap on enabled Invalid, stall, release by STATUS clear
    wr(4'd1, 32'h2);
    xfer(5'b00010, 32'h7FC00000);
    check("irq_trap", 32'(irq), 32'd1);
    check("ready_trap", 32'(in_ready), 32'd0);
    in_valid = 1; in_flags = 5'b00001; in_result = 32'h1234_5678;
    step(); step();
    in_valid = 0;
    rd_chk(4'd2, 32'h7FC00000);
    wr(4'd0, 32'h2);
    step();
    check("ready_release", 32'(in_ready), 32'd1);
    check("irq_release", 32'(irq), 32'd0);

    // W1C collides with a transfer: set wins
    in_valid = 1; in_flags = 5'b00100; in_result = 32'hDEAD_BEEF;
    csr_wr = 1; csr_addr = 4'd0; csr_wdata = 32'h1F;
    step();
    in_valid = 0; csr_wr = 0;
    rd_chk(4'd0, 32'h0000_0004);

    // Counter saturation and clear
    wr(4'd1, 32'h0);
    wr(4'd3, 32'h0);
    for (int i = 0; i < CNT_MAX; i++) xfer(5'b00001, 32'(i));
    rd_chk(4'd3, 32'h0001_0000 | 32'(CNT_MAX));
    xfer(5'b00001, 32'hFFFF);
    rd_chk(4'd3, 32'h0001_0000 | 32'(CNT_MAX));
    wr(4'd3, 32'h5);
    rd_chk(4'd3, 32'h0001_0000);

    // Per-flag counters
    for (int a = 4; a <= 8; a++) wr(4'(a), 32'h0);
    for (int i = 0; i < 3; i++) xfer(5'b01001, 32'(100 + i));
`ifdef FP_FLAG_COUNTERS_EN
    rd_chk(4'd4, 32'd3);
    rd_chk(4'd7, 32'd3);
    rd_chk(4'd5, 32'd0);
    rd_chk(4'd6, 32'd0);
    rd_chk(4'd8, 32'd0);
`else
    rd_chk(4'd4, 32'd0);
`endif

    // Enabling an already-sticky bit does not trap
    wr(4'd1, 32'h8);
    step();
    check("no_trap_sticky", 32'(irq), 32'd0);

    // Reset in the middle of a trap
    wr(4'd1, 32'h1);
    xfer(5'b00001, 32'hCAFE_0001);
    check("irq_before_rst", 32'(irq), 32'd1);
    rst = 1; step(); rst = 0; step();
    rd_chk(4'd0, 32'h0);
    rd_chk(4'd1, 32'h0);
    rd_chk(4'd3, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_flags  = 5'($urandom);
      in_result = $urandom;
      csr_rd    = 1'($urandom_range(0, 1));
      csr_wr    = ($urandom_range(0, 2) == 0);
      csr_addr  = 4'($urandom_range(0, 10));
      csr_wdata = $urandom;
      if (in_valid && m_ready) $display("rand xfer flags=%b result=%h", in_flags, in_result);
      step();
    end
    in_valid = 0; csr_rd = 0; csr_wr = 0;
    for (int a = 0; a < 9; a++) begin
      csr_rd = 1; csr_addr = 4'(a);
      step();
    end
    csr_rd = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
